// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, captures ROM output into IF/ID; one-edge fetch latency, one bubble per redirect.
// Stall is a level hold with no handshake; redirect overrides stall and cancels a pending halt.
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 9,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(1),
    parameter logic [4:0]      HALT_OP  = 5'b11010
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_base,
    input  logic [PC_W-1:0]    redirect_offset,
    input  logic               redirect_dir,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    typedef enum logic {RUN, STOP} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } ifid_t;

    state_t            state, state_nxt;
    ifid_t             ifid, ifid_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [15:0]       count_nxt;
    logic [PC_W-1:0]   target;
    logic              is_halt;

    // Modulo-2^PC_W arithmetic: wrap in either direction is intentionally silent.
    assign target  = redirect_dir ? (redirect_base + redirect_offset)
                                  : (redirect_base - redirect_offset);
    assign is_halt = (rom_instr[INSTR_W-1 -: 5] == HALT_OP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            ifid        <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ifid        <= ifid_nxt;
            fetch_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ifid_nxt  = ifid;
        count_nxt = fetch_count;
        if (redirect) begin
            // Flush keeps ifid.pc so decode still sees the last real PC.
            pc_nxt         = target;
            ifid_nxt.instr = '0;
            ifid_nxt.valid = 1'b0;
            state_nxt      = RUN;
        end else if (stall) begin
            // everything holds
        end else if (state == STOP) begin
            ifid_nxt.instr = '0;
            ifid_nxt.valid = 1'b0;
        end else begin
            ifid_nxt.instr = rom_instr;
            ifid_nxt.pc    = pc;
            ifid_nxt.valid = 1'b1;
            if (fetch_count != 16'hFFFF)
                count_nxt = fetch_count + 16'd1;
            if (is_halt)
                state_nxt = STOP;
            else
                pc_nxt = pc + PC_W'(1);
        end
    end

    assign ifid_instr = ifid.instr;
    assign ifid_pc    = ifid.pc;
    assign ifid_valid = ifid.valid;
    assign halted     = (state == STOP);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the instruction ROM and feeds its output into the IF/ID pipeline register. It owns the 16-bit program counter and drives it to the ROM's `pc` input. It captures the returned 9-bit instruction together with its PC into the IF/ID register, and applies stall, branch/jump redirect (relative offset with direction) and halt handling. Decode consumes `ifid_*`; execute drives the redirect inputs.

## Interface
- `PC_W`, 16, program-counter width
- `INSTR_W`, 9, instruction width (5-bit opcode + 4-bit operand)
- `RESET_PC`, 1, first fetched address (address 0 is unused)
- `HALT_OP`, 5'b11010, opcode that stops fetch

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pc`  out  PC_W  fetch address to instruction ROM
- `rom_instr`  in  INSTR_W  ROM output for `pc`, combinational, same cycle
- `stall`  in  1  hold PC and IF/ID (decode hazard)
- `redirect`  in  1  taken branch/jump resolved downstream
- `redirect_base`  in  PC_W  PC of the branch/jump instruction
- `redirect_offset`  in  PC_W  unsigned offset (the `$adr` value)
- `redirect_dir`  in  1  1 = positive (base+offset), 0 = negative (base-offset)
- `ifid_instr`  out  INSTR_W  registered instruction
- `ifid_pc`  out  PC_W  PC of `ifid_instr`
- `ifid_valid`  out  1  `ifid_instr` is a real instruction, not a bubble
- `halted`  out  1  fetch stopped on a HALT_OP
- `fetch_count`  out  16  number of valid instructions captured, saturating

## Operation
- States: RUN and STOP; reset enters RUN.
- Per-cycle priority: redirect > stall > STOP > normal fetch.
- **Redirect** (any state, including during stall):
  - PC loads target: `redirect_base + redirect_offset` if `redirect_dir=1`, else `redirect_base - redirect_offset`.
  - Target is computed modulo 2^PC_W, so wrap is silent.
  - IF/ID is flushed: `ifid_valid=0`, `ifid_instr=0`, `ifid_pc` holds.
  - State goes to RUN, which cancels a wrong-path halt.
- **Stall** (no redirect): PC, IF/ID, state and `fetch_count` all hold.
- **RUN, normal fetch:**
  - `ifid_instr` loads `rom_instr`, `ifid_pc` loads `pc`, `ifid_valid` goes to 1.
  - `fetch_count` increments by 1 (saturates at 16'hFFFF).
  - If `rom_instr[8:4]==HALT_OP`: PC holds and the state goes to STOP.
  - Otherwise PC increments by 1; 16'hFFFF wraps to 0.
- **STOP** (no redirect, no stall):
  - PC holds and `ifid_valid=0` (bubble).
  - The HALT instruction stays visible for exactly one cycle, then bubbles follow.
- `halted` is 1 exactly when the state is STOP.
- Width rules: offset arithmetic is PC_W-bit unsigned; `fetch_count` does not wrap.

## Timing
- Reset values (asynchronous, immediate):
  - `pc=RESET_PC` (1), `ifid_instr=0`, `ifid_pc=0`, `ifid_valid=0`, `halted=0`, `fetch_count=0`, state RUN.
- ROM path is combinational: `rom_instr` for `pc` is sampled at the same rising edge.
- Fetch latency: instruction at address A appears on `ifid_instr` one edge after `pc==A`.
- Redirect latency:
  - `redirect` sampled high at edge N sets `pc=target` after N.
  - The target instruction is in IF/ID after edge N+1.
  - Exactly one bubble is inserted.
- The stall input is level-sensitive and has no handshake.
- Reset asserted mid-operation (including in STOP or during stall) returns all state to reset values within the same cycle, with no clock required.
- Simultaneous redirect and HALT_OP on `rom_instr`: redirect wins, the halt is discarded and the state stays RUN.

## Test plan
- **Reset/sequential:**
  - Stimulus: release reset, ROM returns `{5'b00110,4'b0001}` at pc 1, no stall or redirect.
  - Required: after edge 1, `ifid_instr=9'b001100001`, `ifid_pc=1`, `ifid_valid=1`, `pc=2`, `fetch_count=1`.
- **Stall:**
  - Stimulus: `stall=1` for 3 cycles at `pc=5`.
  - Required: `pc`, `ifid_*` and `fetch_count` unchanged for 3 edges; the fetch at pc 5 is captured on the first edge after release.
- **Redirect backward, during stall:**
  - Stimulus: `redirect=1`, `redirect_base=73`, `redirect_offset=57`, `redirect_dir=0`, with `stall=1`.
  - Required: `pc=16`, `ifid_valid=0`; ROM[16] is in IF/ID one edge later.
- **Redirect forward with wrap:**
  - Stimulus: `redirect_base=16'hFFF0`, `redirect_offset=16'h0020`, `redirect_dir=1`.
  - Required: `pc=16'h0010`.
- **Halt:**
  - Stimulus: ROM returns `{5'b11010,4'b0000}` at pc 81.
  - Required: `ifid_instr=9'b110100000` for one cycle, then `ifid_valid=0`, `pc` stuck at 81, `halted=1`.
  - Follow-up: a subsequent redirect to 10 clears `halted` and fetch resumes at 10.
- **Saturation and async reset:**
  - Stimulus: preload `fetch_count` near 16'hFFFF via a long run, then assert `reset` between edges.
  - Required: `fetch_count` holds at 16'hFFFF; on reset, all outputs return to reset values before the next edge.
